// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM state encoding,
// nibble width and the WIDTH legality check used at elaboration.
package nibble_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    function automatic bit width_ok(input int w);
        return (w >= NIB_W) && ((w % NIB_W) == 0);
    endfunction

endpackage

// File: rtl/nibble_cla_slice.sv
// Combinational 4-bit carry-lookahead slice. With NIBBLE_ADD_OVF_EN defined the
// carry into the top bit (c3) is exported for signed-overflow detection.
module nibble_cla_slice
    import nibble_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
`ifdef NIBBLE_ADD_OVF_EN
    ,
    output logic             c3
`endif
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    assign g = a & b;
    assign p = a | b;

    // Every carry is a flat sum of products of g, p and cin, so no ripple path.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = a ^ b ^ c[NIB_W-1:0];
    assign cout = c[NIB_W];

`ifdef NIBBLE_ADD_OVF_EN
    assign c3 = c[NIB_W-1];
`endif

endmodule

// File: rtl/nibble_add_sequencer.sv
// WIDTH-bit adder that streams operands one nibble per clock through a single
// CLA slice. Optional signed-overflow output ovf enabled by NIBBLE_ADD_OVF_EN.
module nibble_add_sequencer
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result
`ifdef NIBBLE_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("nibble_add_sequencer: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             state_q, state_d;
    logic               load, step;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   sum_q, sum_nxt;
    logic [WIDTH:0]     result_q;
    logic [NIB_W-1:0]   slice_a, slice_b, slice_sum;
    logic               slice_cout;
`ifdef NIBBLE_ADD_OVF_EN
    logic               slice_c3;
    logic               ovf_q;
`endif

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign slice_a = a_q[idx_q*NIB_W +: NIB_W];
    assign slice_b = b_q[idx_q*NIB_W +: NIB_W];

    nibble_cla_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
`ifdef NIBBLE_ADD_OVF_EN
        ,
        .c3   (slice_c3)
`endif
    );

    // Merge the current nibble so the final cycle can publish the full sum directly.
    always_comb begin
        sum_nxt = sum_q;
        sum_nxt[idx_q*NIB_W +: NIB_W] = slice_sum;
    end

    // Operand capture: plain data, only the load strobe matters.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            result_q <= '0;
`ifdef NIBBLE_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (load) begin
                carry_q <= cin;
                idx_q   <= '0;
                sum_q   <= '0;
            end else if (step) begin
                sum_q   <= sum_nxt;
                carry_q <= slice_cout;
                if (idx_q == LAST_IDX) begin
                    result_q <= {slice_cout, sum_nxt};
`ifdef NIBBLE_ADD_OVF_EN
                    ovf_q    <= slice_c3 ^ slice_cout;
`endif
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign result = result_q;
`ifdef NIBBLE_ADD_OVF_EN
    assign ovf = ovf_q;
`endif

endmodule
